// File: rtl/amdc_dac_spi_seq.sv
// ============================================================================
// Module   : amdc_dac_spi_seq
// Brief    : Multi-channel DAC update sequencer. Snapshots channel codes on a
//            trigger, sends one SPI frame per enabled channel, then pulses LDAC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module amdc_dac_spi_seq #(
    parameter int         NUM_CH    = 8,
    parameter int         DATA_W    = 16,
    parameter int         FRAME_W   = 24,
    parameter int         CLK_DIV   = 2,
    parameter int         SYNC_HIGH = 4,
    parameter int         LDAC_W    = 4,
    parameter logic [3:0] CMD_WRITE = 4'h0
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     trigger,
    output logic                     sclk,
    output logic                     sync_n,
    output logic                     mosi,
    output logic                     ldac_n,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int C_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_HALF_W  = $clog2(2*FRAME_W + 1);
    localparam int C_CNT_MAX = (SYNC_HIGH > LDAC_W) ? SYNC_HIGH : LDAC_W;
    localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX) : 1;
    localparam int C_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_HALF_W-1:0] C_HALF_LAST = C_HALF_W'(2*FRAME_W);
    localparam logic [C_CNT_W-1:0]  C_GAP_LAST  = C_CNT_W'(SYNC_HIGH - 1);
    localparam logic [C_CNT_W-1:0]  C_LDAC_LAST = C_CNT_W'(LDAC_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_LDAC   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]               r_state;
    logic [NUM_CH*DATA_W-1:0] r_data;
    logic [NUM_CH-1:0]        r_en;
    logic [NUM_CH-1:0]        r_sent;
    logic [FRAME_W-1:0]       r_sh;
    logic [C_DIV_W-1:0]       r_div;
    logic [C_HALF_W-1:0]      r_half;
    logic [C_CNT_W-1:0]       r_cnt;

    logic                     w_found;
    logic [C_CH_W-1:0]        w_ch;
    logic [FRAME_W-1:0]       w_frame;

    // Descending scan so the lowest pending index is the one that sticks.
    always_comb begin
        w_found = 1'b0;
        w_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_en[i] && !r_sent[i]) begin
                w_found = 1'b1;
                w_ch    = C_CH_W'(i);
            end
        end
    end

    always_comb begin
        w_frame                       = '0;
        w_frame[FRAME_W-1 -: 4]       = CMD_WRITE;
        w_frame[FRAME_W-5 -: 4]       = 4'(w_ch);
        w_frame[FRAME_W-9 -: DATA_W]  = r_data[w_ch*DATA_W +: DATA_W];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_en    <= '0;
            r_sent  <= '0;
            r_sh    <= '0;
            r_div   <= '0;
            r_half  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_data  <= ch_data;
                        r_en    <= ch_en;
                        r_sent  <= '0;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        r_sent[w_ch] <= 1'b1;
                        r_sh         <= w_frame;
                        r_div        <= '0;
                        r_half       <= '0;
                        r_state      <= S_SHIFT;
                    end else if (|r_sent) begin
                        r_cnt   <= '0;
                        r_state <= S_LDAC;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_SHIFT: begin
                    // Half 0 is the lead-in; odd halves are sclk high, even halves sclk low.
                    if (r_div == C_DIV_LAST) begin
                        r_div <= '0;
                        if (r_half == C_HALF_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_GAP;
                        end else begin
                            r_half <= r_half + C_HALF_W'(1);
                            if ((r_half != '0) && !r_half[0]) begin
                                r_sh <= {r_sh[FRAME_W-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + C_DIV_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == C_GAP_LAST) begin
                        r_state <= S_SELECT;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                S_LDAC: begin
                    if (r_cnt == C_LDAC_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pins decode straight from state so an async reset releases them immediately.
    assign sync_n  = (r_state != S_SHIFT);
    assign sclk    = (r_state == S_SHIFT) && r_half[0];
    assign mosi    = (r_state == S_SHIFT) && (r_half != '0) && r_sh[FRAME_W-1];
    assign ldac_n  = (r_state != S_LDAC);
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign overrun = trigger && (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_amdc_dac_spi_seq.sv
// ============================================================================
// Module   : tb_amdc_dac_spi_seq
// Brief    : Directed self-checking bench; an SPI monitor decodes frames.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_amdc_dac_spi_seq;

    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n  = 1'b0;
    logic [4*DW-1:0] data_a = '0;
    logic [3:0]      en_a   = '0;
    logic            trig_a = 1'b0;
    logic [8*DW-1:0] data_b = '0;
    logic [7:0]      en_b   = '0;
    logic            trig_b = 1'b0;

    logic sclk_a, sync_a, mosi_a, ldac_a, busy_a, done_a, ovr_a;
    logic sclk_b, sync_b, mosi_b, ldac_b, busy_b, done_b, ovr_b;

    amdc_dac_spi_seq #(
        .NUM_CH(4), .DATA_W(DW), .FRAME_W(24), .CLK_DIV(2),
        .SYNC_HIGH(4), .LDAC_W(4), .CMD_WRITE(4'h0)
    ) u_dut_a (
        .ACLK(clk), .ARESETN(rst_n), .ch_data(data_a), .ch_en(en_a), .trigger(trig_a),
        .sclk(sclk_a), .sync_n(sync_a), .mosi(mosi_a), .ldac_n(ldac_a),
        .busy(busy_a), .done(done_a), .overrun(ovr_a)
    );

    amdc_dac_spi_seq #(
        .NUM_CH(8), .DATA_W(DW), .FRAME_W(24), .CLK_DIV(1),
        .SYNC_HIGH(4), .LDAC_W(4), .CMD_WRITE(4'h0)
    ) u_dut_b (
        .ACLK(clk), .ARESETN(rst_n), .ch_data(data_b), .ch_en(en_b), .trigger(trig_b),
        .sclk(sclk_b), .sync_n(sync_b), .mosi(mosi_b), .ldac_n(ldac_b),
        .busy(busy_b), .done(done_b), .overrun(ovr_b)
    );

    logic mon_sel = 1'b0;
    logic m_sclk, m_sync, m_mosi, m_ldac, m_busy, m_done, m_ovr;
    assign m_sclk = mon_sel ? sclk_b : sclk_a;
    assign m_sync = mon_sel ? sync_b : sync_a;
    assign m_mosi = mon_sel ? mosi_b : mosi_a;
    assign m_ldac = mon_sel ? ldac_b : ldac_a;
    assign m_busy = mon_sel ? busy_b : busy_a;
    assign m_done = mon_sel ? done_b : done_a;
    assign m_ovr  = mon_sel ? ovr_b  : ovr_a;

    int n_chk  = 0;
    int n_pass = 0;

    // SPI/DAC pin monitor: decodes each sync_n-low window into a frame record.
    int          n_fr = 0, n_ldac_fall = 0, n_ldac_low = 0, n_done = 0, n_ovr = 0;
    int          n_sclk_rise = 0, n_sync_low = 0;
    logic [23:0] fr_word [16];
    int          fr_low  [16];
    int          fr_bits [16];
    int          fr_gap  [16];
    int          fr_ldac [16];
    logic [23:0] cur = '0;
    int          cur_low = 0, cur_bits = 0, hi_run = 0;
    logic        p_sync = 1'b1, p_sclk = 1'b0, p_ldac = 1'b1;

    always @(negedge clk) begin
        if (m_done) n_done++;
        if (m_ovr) n_ovr++;
        if (!m_ldac) n_ldac_low++;
        if (!m_ldac && p_ldac) n_ldac_fall++;
        if (m_sclk && !p_sclk) n_sclk_rise++;
        if (!m_sync) begin
            n_sync_low++;
            if (p_sync) begin
                cur = '0; cur_low = 0; cur_bits = 0;
                if (n_fr < 16) begin
                    fr_gap[n_fr]  = hi_run;
                    fr_ldac[n_fr] = n_ldac_fall;
                end
            end
            cur_low++;
            if (m_sclk && !p_sclk) begin
                cur = {cur[22:0], m_mosi};
                cur_bits++;
            end
            hi_run = 0;
        end else begin
            if (!p_sync) begin
                if (n_fr < 16) begin
                    fr_word[n_fr] = cur;
                    fr_low[n_fr]  = cur_low;
                    fr_bits[n_fr] = cur_bits;
                end
                n_fr++;
            end
            hi_run++;
        end
        p_sync = m_sync;
        p_sclk = m_sclk;
        p_ldac = m_ldac;
    end

    task automatic clear_stats();
        @(posedge clk); #1;
        n_fr = 0; n_ldac_fall = 0; n_ldac_low = 0; n_done = 0; n_ovr = 0;
        n_sclk_rise = 0; n_sync_low = 0;
    endtask

    task automatic pulse_trig();
        @(posedge clk); #1;
        if (mon_sel) trig_b = 1'b1; else trig_a = 1'b1;
        @(posedge clk); #1;
        trig_a = 1'b0;
        trig_b = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++; if (sync_a !== 1'b1) $display("FAIL rst_sync_n: got %b want 1", sync_a); else n_pass++;
        n_chk++; if (sclk_a !== 1'b0) $display("FAIL rst_sclk: got %b want 0", sclk_a); else n_pass++;
        n_chk++; if (mosi_a !== 1'b0) $display("FAIL rst_mosi: got %b want 0", mosi_a); else n_pass++;
        n_chk++; if (ldac_a !== 1'b1) $display("FAIL rst_ldac_n: got %b want 1", ldac_a); else n_pass++;
        n_chk++; if ({busy_a, done_a, ovr_a} !== 3'b000)
            $display("FAIL rst_flags: got busy/done/ovr=%b want 000", {busy_a, done_a, ovr_a}); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        en_a   = 4'b0001;
        data_a = {12'h000, 12'h000, 12'h000, 12'hABC};
        clear_stats();
        pulse_trig();
        wait_idle(400, ok);
        n_chk++; if (!ok) $display("FAIL t1_timeout: busy still high"); else n_pass++;
        n_chk++; if (n_fr !== 1) $display("FAIL t1_frames: got %0d want 1", n_fr); else n_pass++;
        n_chk++; if (fr_word[0] !== 24'h00ABC0) $display("FAIL t1_word: got %h want 00abc0", fr_word[0]); else n_pass++;
        n_chk++; if (fr_low[0] !== 98) $display("FAIL t1_sync_low: got %0d want 98", fr_low[0]); else n_pass++;
        n_chk++; if (fr_bits[0] !== 24) $display("FAIL t1_bits: got %0d want 24", fr_bits[0]); else n_pass++;
        n_chk++; if (n_ldac_fall !== 1 || n_ldac_low !== 4)
            $display("FAIL t1_ldac: got %0d pulses %0d cycles want 1 pulse 4 cycles", n_ldac_fall, n_ldac_low); else n_pass++;
        n_chk++; if (n_done !== 1) $display("FAIL t1_done: got %0d want 1", n_done); else n_pass++;
        n_chk++; if (n_ovr !== 0) $display("FAIL t1_overrun: got %0d want 0", n_ovr); else n_pass++;
    endtask

    task automatic test_two_frames();
        bit ok;
        en_a   = 4'b1010;
        data_a = {12'hFFF, 12'h000, 12'h123, 12'h000};
        clear_stats();
        pulse_trig();
        wait_idle(600, ok);
        n_chk++; if (!ok) $display("FAIL t2_timeout: busy still high"); else n_pass++;
        n_chk++; if (n_fr !== 2) $display("FAIL t2_frames: got %0d want 2", n_fr); else n_pass++;
        n_chk++; if (fr_word[0] !== 24'h011230) $display("FAIL t2_word0: got %h want 011230", fr_word[0]); else n_pass++;
        n_chk++; if (fr_word[1] !== 24'h03FFF0) $display("FAIL t2_word1: got %h want 03fff0", fr_word[1]); else n_pass++;
        // sync_n stays high for the GAP cycles plus the one SELECT cycle.
        n_chk++; if (fr_gap[1] !== 5) $display("FAIL t2_gap: got %0d want 5", fr_gap[1]); else n_pass++;
        n_chk++; if (fr_ldac[1] !== 0) $display("FAIL t2_early_ldac: got %0d want 0", fr_ldac[1]); else n_pass++;
        n_chk++; if (n_ldac_fall !== 1 || n_ldac_low !== 4)
            $display("FAIL t2_ldac: got %0d pulses %0d cycles want 1 pulse 4 cycles", n_ldac_fall, n_ldac_low); else n_pass++;
    endtask

    task automatic test_empty();
        en_a = 4'b0000;
        clear_stats();
        pulse_trig();
        @(negedge clk);
        n_chk++; if ({busy_a, done_a} !== 2'b10) $display("FAIL t3_select: got busy/done=%b want 10", {busy_a, done_a}); else n_pass++;
        @(negedge clk);
        n_chk++; if ({busy_a, done_a} !== 2'b11) $display("FAIL t3_done: got busy/done=%b want 11", {busy_a, done_a}); else n_pass++;
        @(negedge clk);
        n_chk++; if ({busy_a, done_a} !== 2'b00) $display("FAIL t3_idle: got busy/done=%b want 00", {busy_a, done_a}); else n_pass++;
        n_chk++; if (n_sync_low !== 0 || n_sclk_rise !== 0 || n_ldac_fall !== 0)
            $display("FAIL t3_quiet: got sync_low=%0d sclk=%0d ldac=%0d want 0", n_sync_low, n_sclk_rise, n_ldac_fall); else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        en_a   = 4'b0001;
        data_a = {12'h000, 12'h000, 12'h000, 12'hABC};
        clear_stats();
        pulse_trig();
        repeat (20) @(posedge clk);
        #1;
        data_a[11:0] = 12'h555;
        en_a         = 4'b1111;
        trig_a       = 1'b1;
        repeat (3) @(posedge clk);
        #1 trig_a = 1'b0;
        wait_idle(400, ok);
        n_chk++; if (!ok) $display("FAIL t4_timeout: busy still high"); else n_pass++;
        n_chk++; if (n_ovr !== 3) $display("FAIL t4_overrun: got %0d want 3", n_ovr); else n_pass++;
        n_chk++; if (fr_word[0] !== 24'h00ABC0) $display("FAIL t4_word: got %h want 00abc0", fr_word[0]); else n_pass++;
        repeat (10) @(negedge clk);
        n_chk++; if (n_fr !== 1 || busy_a !== 1'b0 || n_done !== 1)
            $display("FAIL t4_no_restart: got frames=%0d busy=%b done=%0d want 1 0 1", n_fr, busy_a, n_done); else n_pass++;
        en_a = 4'b0001;
        data_a[11:0] = 12'hABC;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bit seen;
        clear_stats();
        pulse_trig();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!sync_a) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++; if (!seen) $display("FAIL t5_start: sync_n never went low"); else n_pass++;
        // 43 cycles into the frame is the second sclk-high cycle of bit 10 (a '1').
        repeat (43) @(negedge clk);
        n_chk++; if ({sclk_a, mosi_a} !== 2'b11) $display("FAIL t5_bit10: got sclk/mosi=%b want 11", {sclk_a, mosi_a}); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({sync_a, sclk_a, ldac_a, busy_a} !== 4'b1010)
            $display("FAIL t5_async: got sync/sclk/ldac/busy=%b want 1010", {sync_a, sclk_a, ldac_a, busy_a}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        pulse_trig();
        wait_idle(400, ok);
        n_chk++; if (!ok || n_fr !== 1 || fr_word[0] !== 24'h00ABC0 || fr_low[0] !== 98)
            $display("FAIL t5_after: got ok=%b frames=%0d word=%h low=%0d want 1 1 00abc0 98",
                     ok, n_fr, fr_word[0], fr_low[0]); else n_pass++;
        n_chk++; if (n_ldac_fall !== 1 || n_done !== 1)
            $display("FAIL t5_ldac_done: got ldac=%0d done=%0d want 1 1", n_ldac_fall, n_done); else n_pass++;
    endtask

    task automatic test_eight_channels();
        bit          ok;
        logic [23:0] exp;
        mon_sel = 1'b1;
        en_b    = 8'hFF;
        for (int i = 0; i < 8; i++) data_b[i*DW +: DW] = 12'(i);
        clear_stats();
        pulse_trig();
        wait_idle(2000, ok);
        n_chk++; if (!ok) $display("FAIL t6_timeout: busy still high"); else n_pass++;
        n_chk++; if (n_fr !== 8) $display("FAIL t6_frames: got %0d want 8", n_fr); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            exp = 24'((i << 16) | (i << 4));
            n_chk++; if (fr_word[i] !== exp) $display("FAIL t6_word%0d: got %h want %h", i, fr_word[i], exp); else n_pass++;
            n_chk++; if (fr_low[i] !== 49) $display("FAIL t6_low%0d: got %0d want 49", i, fr_low[i]); else n_pass++;
        end
        n_chk++; if (n_ldac_fall !== 1 || n_ldac_low !== 4 || n_done !== 1)
            $display("FAIL t6_ldac_done: got ldac=%0d/%0d done=%0d want 1/4 1", n_ldac_fall, n_ldac_low, n_done); else n_pass++;
        mon_sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_frames();
        test_empty();
        test_overrun();
        test_reset_mid_frame();
        test_eight_channels();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
